// File: rtl/prbs_pkg.sv
// Shared definitions for the XNOR-feedback PRBS generator/checker pair.
// State encoding, tap offsets and the lockup pattern live here.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int DEF_W = 4;

  // Taps are s[W-TAP_HI_OFS] and s[W-TAP_LO_OFS].
  localparam int TAP_HI_OFS = 1;
  localparam int TAP_LO_OFS = 2;

  localparam logic [63:0] LOCKUP = '1;

endpackage

// File: rtl/prbs_if.sv
// Serial bit-stream bundle between a PRBS source and the checker.
// master drives the stream; slave is the checker side.
interface prbs_if #(
  parameter int ERR_W = 16
);
  logic             din;
  logic             din_valid;
  logic             clear;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic             lock_lost;

  modport master (
    output din, din_valid, clear,
    input  locked, err, err_count, lock_lost
  );

  modport slave (
    input  din, din_valid, clear,
    output locked, err, err_count, lock_lost
  );
endinterface

// File: rtl/prbs_step.sv
// Next-bit function x^W + x^(W-1) + 1 with XNOR feedback.
// Shared by generator and checker so both ends use one polynomial.
module prbs_step
  import prbs_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] s,
  output logic         nb
);
  assign nb = ~(s[W-TAP_HI_OFS] ^ s[W-TAP_LO_OFS]);
endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds from the stream,
// verifies, then free-runs and counts bit errors while locked.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input logic  clk,
  input logic  reset,
  prbs_if.slave bus
);
  localparam int SW = $clog2(W + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  logic [W-1:0]     s_q, s_d;
  logic [SW-1:0]    seed_q, seed_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;
  logic             loss;
  logic             exp_bit;

  prbs_step #(.W(W)) u_step (
    .s  (s_q),
    .nb (exp_bit)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    seed_d  = seed_q;
    match_d = match_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    loss    = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        SEARCH: begin
          s_d = {s_q[W-2:0], bus.din};
          if (seed_q == SW'(W - 1)) begin
            state_d = VERIFY;
            seed_d  = '0;
            match_d = '0;
          end else begin
            seed_d = seed_q + 1'b1;
          end
        end
        VERIFY: begin
          s_d = {s_q[W-2:0], bus.din};
          if (bus.din != exp_bit) begin
            state_d = SEARCH;
            seed_d  = '0;
          end else if (match_q == MW'(LOCK_COUNT - 1)) begin
            match_d = '0;
            miss_d  = '0;
            seed_d  = '0;
            // All-ones never leaves itself under XNOR feedback.
            if (s_d == LOCKUP[W-1:0]) state_d = SEARCH;
            else                      state_d = LOCKED;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        LOCKED: begin
          s_d = {s_q[W-2:0], exp_bit};
          if (bus.din != exp_bit) begin
            err_d = 1'b1;
            if (cnt_q != ERR_MAX) cnt_d = cnt_q + 1'b1;
            if (miss_q == LW'(LOSS_COUNT - 1)) begin
              state_d = SEARCH;
              seed_d  = '0;
              miss_d  = '0;
              loss    = 1'b1;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (bus.clear) cnt_d = '0;
    lost_d   = (lost_q & ~bus.clear) | loss;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEARCH;
      s_q      <= '0;
      seed_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      seed_q   <= seed_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = cnt_q;
  assign bus.lock_lost = lost_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: two instances (ERR_W 16 and 2)
// share one stimulus stream; expectations are queued per step.
module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs_if #(.ERR_W(16)) ifa ();
  prbs_if #(.ERR_W(2))  ifb ();

  prbs_checker #(
    .W(4), .LOCK_COUNT(8), .LOSS_COUNT(4), .ERR_W(16)
  ) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa)
  );

  prbs_checker #(
    .W(4), .LOCK_COUNT(8), .LOSS_COUNT(4), .ERR_W(2)
  ) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb)
  );

  typedef struct packed {
    logic        la;
    logic        ea;
    logic [15:0] ca;
    logic        sa;
    logic        lb;
    logic        eb;
    logic [1:0]  cb;
    logic        sb;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [3:0] gen_s;
  logic  b;

  task automatic next_bit(output logic nb);
    nb    = ~(gen_s[3] ^ gen_s[2]);
    gen_s = {gen_s[2:0], nb};
  endtask

  task automatic step(
    input string tag,
    input logic  d, v, c,
    input logic  xl, xe,
    input int    xc,
    input logic  xs
  );
    obs_t  e, o;
    string t;
    @(negedge clk);
    ifa.din = d; ifa.din_valid = v; ifa.clear = c;
    ifb.din = d; ifb.din_valid = v; ifb.clear = c;
    e.la = xl; e.ea = xe; e.ca = 16'(xc); e.sa = xs;
    e.lb = xl; e.eb = xe; e.sb = xs;
    e.cb = (xc > 3) ? 2'd3 : 2'(xc);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    o = {ifa.locked, ifa.err, ifa.err_count, ifa.lock_lost,
         ifb.locked, ifb.err, ifb.err_count, ifb.lock_lost};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask

  initial begin
    ifa.din = 1'b0; ifa.din_valid = 1'b0; ifa.clear = 1'b0;
    ifb.din = 1'b0; ifb.din_valid = 1'b0; ifb.clear = 1'b0;

    rst = 1'b1;
    step("reset", 1, 1, 1, 0, 0, 0, 0);
    step("reset", 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;

    gen_s = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      next_bit(b);
      step("clean_lock", b, 1, 0, i == 12, 0, 0, 0);
    end
    for (int i = 0; i < 60; i++) begin
      next_bit(b);
      step("clean_run", b, 1, 0, 1, 0, 0, 0);
    end

    next_bit(b);
    step("single_err", ~b, 1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      next_bit(b);
      step("post_err", b, 1, 0, 1, 0, 1, 0);
    end

    for (int k = 0; k < 4; k++) begin
      next_bit(b);
      step("loss", ~b, 1, 0, k < 3, 1, 2 + k, k == 3);
    end
    for (int i = 1; i <= 12; i++) begin
      next_bit(b);
      step("relock", b, 1, 0, i == 12, 0, 5, 1);
    end

    rst = 1'b1;
    step("rst_mid", 1, 1, 1, 0, 0, 0, 0);
    rst = 1'b0;

    gen_s = 4'd0;
    for (int i = 0; i < 6; i++) begin
      next_bit(b);
      step("vfy_pre", b, 1, 0, 0, 0, 0, 0);
    end
    next_bit(b);
    step("vfy_bad", ~b, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      next_bit(b);
      step("vfy_relock", b, 1, 0, i == 12, 0, 0, 0);
    end

    rst = 1'b1;
    step("rst_lockup", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 36; i++)
      step("lockup", 1, 1, 0, 0, 0, 0, 0);

    gen_s = 4'd0;
    begin
      int nv;
      nv = 0;
      for (int i = 0; i < 24; i++) begin
        if (i % 2 == 0) begin
          next_bit(b);
          nv++;
          step("gap", b, 1, 0, nv == 12, 0, 0, 0);
        end else begin
          step("gap_idle", ~b, 0, 0, nv >= 12, 0, 0, 0);
        end
      end
    end

    for (int e = 1; e <= 5; e++) begin
      next_bit(b);
      step("sat_err", ~b, 1, 0, 1, 1, e, 0);
      for (int i = 0; i < 3; i++) begin
        next_bit(b);
        step("sat_ok", b, 1, 0, 1, 0, e, 0);
      end
    end
    step("hold", 1, 0, 0, 1, 0, 5, 0);
    step("hold", 0, 0, 0, 1, 0, 5, 0);

    next_bit(b);
    step("clear", b, 1, 1, 1, 0, 0, 0);
    next_bit(b);
    step("clr_err", ~b, 1, 1, 1, 1, 0, 0);
    next_bit(b);
    step("clr_ok", b, 1, 0, 1, 0, 0, 0);
    next_bit(b);
    step("err_after_clr", ~b, 1, 0, 1, 1, 1, 0);
    next_bit(b);
    step("clr_ok", b, 1, 0, 1, 0, 1, 0);

    for (int k = 0; k < 4; k++) begin
      next_bit(b);
      step("clr_loss", ~b, 1, k == 3, k < 3, 1,
           (k == 3) ? 0 : 2 + k, k == 3);
    end
    next_bit(b);
    step("lost_hold", b, 1, 0, 0, 0, 0, 1);
    next_bit(b);
    step("clr_lost", b, 1, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
